// File: rtl/instr_fetch_seq_pkg.sv
// rtl/instr_fetch_seq_pkg.sv - shared encodings for the instruction fetch sequencer
package instr_fetch_seq_pkg;

  localparam logic [1:0] FMT_ILLEGAL = 2'd0;
  localparam logic [1:0] FMT_I       = 2'd1;
  localparam logic [1:0] FMT_II      = 2'd2;
  localparam logic [1:0] FMT_JUMP    = 2'd3;

  typedef enum logic [2:0] {
    FS_RESET     = 3'd0,
    FS_FETCH_OP  = 3'd1,
    FS_FETCH_SRC = 3'd2,
    FS_FETCH_DST = 3'd3,
    FS_ISSUE     = 3'd4
  } fetch_state_e;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  localparam logic [1:0] AM_REGISTER     = 2'b00;
  localparam logic [1:0] AM_INDEXED      = 2'b01;
  localparam logic [1:0] AM_INDIRECT     = 2'b10;
  localparam logic [1:0] AM_INDIRECT_INC = 2'b11;

  function automatic logic [1:0] decode_fmt(input logic [15:0] op);
    logic [1:0] f;
    if (op[15:13] == 3'b001) begin
      f = FMT_JUMP;
    end else if (op[15:12] == 4'b0001) begin
      f = FMT_II;
    end else if (op[15:12] >= 4'b0100) begin
      f = FMT_I;
    end else begin
      f = FMT_ILLEGAL;
    end
    return f;
  endfunction

endpackage

// File: rtl/ext_word_count.sv
// rtl/ext_word_count.sv - opcode format and extension-word requirement decode
module ext_word_count
  import instr_fetch_seq_pkg::*;
(
  input  logic [15:0] op_word_i,
  output logic [1:0]  fmt_o,
  output logic        need_src_o,
  output logic        need_dst_o
);

  logic [1:0] as_mode;
  logic [3:0] rs;

  always_comb begin
    fmt_o      = decode_fmt(op_word_i);
    as_mode    = op_word_i[5:4];
    rs         = (fmt_o == FMT_II) ? op_word_i[3:0] : op_word_i[11:8];
    need_src_o = 1'b0;
    need_dst_o = 1'b0;
    // R3 is always the constant generator; R2 only generates constants in the indirect modes
    if ((fmt_o == FMT_I) || (fmt_o == FMT_II)) begin
      if (rs != REG_CG) begin
        if (as_mode == AM_INDEXED) begin
          need_src_o = 1'b1;
        end else if ((as_mode == AM_INDIRECT_INC) && (rs == REG_PC)) begin
          need_src_o = 1'b1;
        end
      end
      need_dst_o = (fmt_o == FMT_I) && op_word_i[7];
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - fetches opcode plus extension words and issues one bundle
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'hC000,
  parameter int               PC_INC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] src_ext,
  output logic [DATA_W-1:0] dst_ext,
  output logic              has_src_ext,
  output logic              has_dst_ext,
  output logic [1:0]        fmt,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              issue_valid,
  input  logic              exec_ready
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              mem_req_q;
  logic              issue_valid_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] src_ext_q;
  logic [DATA_W-1:0] dst_ext_q;
  logic              has_src_q;
  logic              has_dst_q;
  logic [1:0]        fmt_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              need_dst_q;

  logic [1:0] dec_fmt;
  logic       dec_need_src;
  logic       dec_need_dst;

  ext_word_count u_ext_word_count (
    .op_word_i  (mem_rdata[15:0]),
    .fmt_o      (dec_fmt),
    .need_src_o (dec_need_src),
    .need_dst_o (dec_need_dst)
  );

  assign pc_d = pc_q + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_RESET;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      ir_q          <= '0;
      src_ext_q     <= '0;
      dst_ext_q     <= '0;
      has_src_q     <= 1'b0;
      has_dst_q     <= 1'b0;
      fmt_q         <= FMT_ILLEGAL;
      ir_pc_q       <= '0;
      need_dst_q    <= 1'b0;
    end else if (pc_load && (state_q != FS_RESET)) begin
      // Redirect wins over any ack this cycle; the fetched word is dropped
      state_q       <= FS_FETCH_OP;
      pc_q          <= pc_load_val;
      mem_req_q     <= 1'b1;
      issue_valid_q <= 1'b0;
      has_src_q     <= 1'b0;
      has_dst_q     <= 1'b0;
    end else begin
      case (state_q)
        FS_RESET: begin
          state_q   <= FS_FETCH_OP;
          mem_req_q <= 1'b1;
        end
        FS_FETCH_OP: begin
          if (mem_ack) begin
            ir_q       <= mem_rdata;
            ir_pc_q    <= pc_q;
            fmt_q      <= dec_fmt;
            src_ext_q  <= '0;
            dst_ext_q  <= '0;
            has_src_q  <= 1'b0;
            has_dst_q  <= 1'b0;
            need_dst_q <= dec_need_dst;
            pc_q       <= pc_d;
            if (dec_need_src) begin
              state_q <= FS_FETCH_SRC;
            end else if (dec_need_dst) begin
              state_q <= FS_FETCH_DST;
            end else begin
              state_q       <= FS_ISSUE;
              mem_req_q     <= 1'b0;
              issue_valid_q <= 1'b1;
            end
          end
        end
        FS_FETCH_SRC: begin
          if (mem_ack) begin
            src_ext_q <= mem_rdata;
            has_src_q <= 1'b1;
            pc_q      <= pc_d;
            if (need_dst_q) begin
              state_q <= FS_FETCH_DST;
            end else begin
              state_q       <= FS_ISSUE;
              mem_req_q     <= 1'b0;
              issue_valid_q <= 1'b1;
            end
          end
        end
        FS_FETCH_DST: begin
          if (mem_ack) begin
            dst_ext_q     <= mem_rdata;
            has_dst_q     <= 1'b1;
            pc_q          <= pc_d;
            state_q       <= FS_ISSUE;
            mem_req_q     <= 1'b0;
            issue_valid_q <= 1'b1;
          end
        end
        FS_ISSUE: begin
          if (exec_ready) begin
            state_q       <= FS_FETCH_OP;
            mem_req_q     <= 1'b1;
            issue_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= FS_RESET;
          mem_req_q     <= 1'b0;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc_out      = pc_q;
  assign ir          = ir_q;
  assign src_ext     = src_ext_q;
  assign dst_ext     = dst_ext_q;
  assign has_src_ext = has_src_q;
  assign has_dst_ext = has_dst_q;
  assign fmt         = fmt_q;
  assign ir_pc       = ir_pc_q;
  assign issue_valid = issue_valid_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed bench for the instruction fetch sequencer
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        exec_ready;

  logic        mem_req, has_src_ext, has_dst_ext, issue_valid;
  logic [15:0] mem_addr, pc_out, ir, src_ext, dst_ext, ir_pc;
  logic [1:0]  fmt;

  logic        w_mem_req, w_has_src_ext, w_has_dst_ext, w_issue_valid;
  logic [15:0] w_mem_addr, w_pc_out, w_ir, w_src_ext, w_dst_ext, w_ir_pc;
  logic [1:0]  w_fmt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_seq dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc_out(pc_out), .ir(ir), .src_ext(src_ext),
    .dst_ext(dst_ext), .has_src_ext(has_src_ext), .has_dst_ext(has_dst_ext),
    .fmt(fmt), .ir_pc(ir_pc), .issue_valid(issue_valid), .exec_ready(exec_ready)
  );

  instr_fetch_seq #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc_out(w_pc_out), .ir(w_ir), .src_ext(w_src_ext),
    .dst_ext(w_dst_ext), .has_src_ext(w_has_src_ext), .has_dst_ext(w_has_dst_ext),
    .fmt(w_fmt), .ir_pc(w_ir_pc), .issue_valid(w_issue_valid), .exec_ready(exec_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait `delay` cycles with the request pending, then acknowledge with `word`
  task automatic serve(input bit w, input logic [15:0] addr, input logic [15:0] word,
                       input int delay, input string tag);
    for (int i = 0; i < delay; i++) begin
      chk({tag, " req_wait"}, w ? w_mem_req : mem_req, 1);
      tick();
    end
    chk({tag, " req"}, w ? w_mem_req : mem_req, 1);
    chk({tag, " addr"}, w ? w_mem_addr : mem_addr, addr);
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
  endtask

  task automatic accept();
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
    pc_load = 1'b0; pc_load_val = 16'h0; exec_ready = 1'b0;
    tick(); tick();
    chk("rst pc", pc_out, 16'hC000);
    chk("rst req", mem_req, 0);
    chk("rst valid", issue_valid, 0);
    chk("rst ir", ir, 0);
    chk("rst irpc", ir_pc, 0);
    chk("rst fmt", fmt, 0);
    chk("rst flags", {has_src_ext, has_dst_ext}, 0);

    rst = 1'b0;
    tick();
    chk("op1 valid_pre", issue_valid, 0);
    serve(0, 16'hC000, 16'h4506, 0, "op1");
    chk("op1 valid", issue_valid, 1);
    chk("op1 ir", ir, 16'h4506);
    chk("op1 fmt", fmt, 1);
    chk("op1 flags", {has_src_ext, has_dst_ext}, 0);
    chk("op1 irpc", ir_pc, 16'hC000);
    chk("op1 pc", pc_out, 16'hC002);
    chk("op1 req", mem_req, 0);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold valid", issue_valid, 1);
      chk("hold req", mem_req, 0);
      chk("hold ir", ir, 16'h4506);
      chk("hold pc", pc_out, 16'hC002);
    end
    accept();
    chk("acc valid", issue_valid, 0);
    chk("acc req", mem_req, 1);
    chk("acc addr", mem_addr, 16'hC002);

    serve(0, 16'hC002, 16'h40B7, 2, "imm op");
    chk("imm valid_mid", issue_valid, 0);
    serve(0, 16'hC004, 16'h1234, 2, "imm src");
    serve(0, 16'hC006, 16'h0004, 2, "imm dst");
    chk("imm valid", issue_valid, 1);
    chk("imm src_ext", src_ext, 16'h1234);
    chk("imm dst_ext", dst_ext, 16'h0004);
    chk("imm flags", {has_src_ext, has_dst_ext}, 2'b11);
    chk("imm irpc", ir_pc, 16'hC002);
    chk("imm pc", pc_out, 16'hC008);
    accept();

    serve(0, 16'hC008, 16'h4314, 0, "cg op");
    chk("cg valid", issue_valid, 1);
    chk("cg flags", {has_src_ext, has_dst_ext}, 0);
    chk("cg src_ext", src_ext, 0);
    chk("cg pc", pc_out, 16'hC00A);
    accept();

    serve(0, 16'hC00A, 16'h4214, 1, "abs op");
    serve(0, 16'hC00C, 16'h0200, 0, "abs src");
    chk("abs valid", issue_valid, 1);
    chk("abs flags", {has_src_ext, has_dst_ext}, 2'b10);
    chk("abs src_ext", src_ext, 16'h0200);
    chk("abs dst_ext", dst_ext, 0);
    chk("abs irpc", ir_pc, 16'hC00A);
    chk("abs pc", pc_out, 16'hC00E);
    accept();

    serve(0, 16'hC00E, 16'h40B7, 0, "fl op");
    chk("fl src addr", mem_addr, 16'hC010);
    pc_load = 1'b1; pc_load_val = 16'hC100;
    mem_ack = 1'b1; mem_rdata = 16'hABCD;
    tick();
    pc_load = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
    chk("fl req", mem_req, 1);
    chk("fl addr", mem_addr, 16'hC100);
    chk("fl valid", issue_valid, 0);
    chk("fl flags", {has_src_ext, has_dst_ext}, 0);
    chk("fl src_ext", src_ext, 0);
    serve(0, 16'hC100, 16'h4506, 0, "fl op2");
    chk("fl2 irpc", ir_pc, 16'hC100);
    chk("fl2 pc", pc_out, 16'hC102);

    pc_load = 1'b1; pc_load_val = 16'hC200; exec_ready = 1'b1;
    tick();
    pc_load = 1'b0; exec_ready = 1'b0;
    chk("ld+rdy addr", mem_addr, 16'hC200);
    chk("ld+rdy valid", issue_valid, 0);
    chk("ld+rdy req", mem_req, 1);
    chk("ld+rdy ir", ir, 16'h4506);

    serve(0, 16'hC200, 16'h3C15, 0, "jmp");
    chk("jmp valid", issue_valid, 1);
    chk("jmp fmt", fmt, 3);
    chk("jmp flags", {has_src_ext, has_dst_ext}, 0);
    chk("jmp pc", pc_out, 16'hC202);
    accept();

    serve(0, 16'hC202, 16'h1290, 0, "f2 op");
    serve(0, 16'hC204, 16'h0010, 0, "f2 src");
    chk("f2 fmt", fmt, 2);
    chk("f2 flags", {has_src_ext, has_dst_ext}, 2'b10);
    chk("f2 src_ext", src_ext, 16'h0010);
    chk("f2 pc", pc_out, 16'hC206);
    accept();

    serve(0, 16'hC206, 16'h0ABC, 0, "ill");
    chk("ill valid", issue_valid, 1);
    chk("ill fmt", fmt, 0);
    chk("ill flags", {has_src_ext, has_dst_ext}, 0);
    chk("ill pc", pc_out, 16'hC208);

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("w start pc", w_pc_out, 16'hFFFE);
    serve(1, 16'hFFFE, 16'h45A4, 0, "w op");
    chk("w dst addr", w_mem_addr, 16'h0000);
    serve(1, 16'h0000, 16'h0006, 1, "w dst");
    chk("w valid", w_issue_valid, 1);
    chk("w flags", {w_has_src_ext, w_has_dst_ext}, 2'b01);
    chk("w dst_ext", w_dst_ext, 16'h0006);
    chk("w irpc", w_ir_pc, 16'hFFFE);
    chk("w pc", w_pc_out, 16'h0002);
    accept();

    serve(1, 16'h0002, 16'h45A4, 0, "w op2");
    chk("w2 dst addr", w_mem_addr, 16'h0004);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
    chk("wr pc", w_pc_out, 16'hFFFE);
    chk("wr req", w_mem_req, 0);
    chk("wr valid", w_issue_valid, 0);
    chk("wr ir", w_ir, 0);
    chk("wr ext", {w_src_ext, w_dst_ext}, 0);
    chk("wr flags", {w_has_src_ext, w_has_dst_ext}, 0);
    chk("wr fmt", w_fmt, 0);
    chk("wr irpc", w_ir_pc, 0);
    tick();
    chk("wr refetch req", w_mem_req, 1);
    chk("wr refetch addr", w_mem_addr, 16'hFFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
